fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Read-side consumer of sync_fifo on the DDR-to-UART return path.
- Pops one byte at a time from the FIFO read port and serializes it as 8N1 UART: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Sits between sync_fifo (data_out/empty/r_en) and the board TX pin, mirroring the UART RX block that fills the write side.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range >= 2.
- DATA_WIDTH, 8, FIFO word and frame data width; only 8 is supported.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- fifo_empty  input  1  sync_fifo empty flag.
- fifo_data  input  DATA_WIDTH  sync_fifo data_out; valid the cycle after r_en is sampled high.
- fifo_r_en  output  1  read strobe to sync_fifo r_en; one-cycle pulse per byte.
- tx  output  1  serial line; idle high.
- busy  output  1  high whenever a fetch or frame is in progress.
- tx_done  output  1  one-cycle pulse after each stop bit completes.

Behaviour:
- Reset: rst=0 at a clk edge forces state=IDLE, tx=1, fifo_r_en=0, busy=0, tx_done=0, baud counter=0, bit index=0, shift register=0. All outputs are registers or decodes of the state register; no combinational path from inputs to outputs.
- States: IDLE, RD_REQ, RD_WAIT, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If fifo_empty=0, go to RD_REQ; else stay.
- RD_REQ (1 cycle):
  - fifo_r_en=1 (decoded from state), tx=1, busy=1.
  - Go to RD_WAIT.
- RD_WAIT (1 cycle):
  - fifo_r_en=0, tx=1.
  - Capture fifo_data into the shift register at the end of this cycle.
  - Go to START.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles; baud counter counts 0..CLKS_PER_BIT-1, then clears.
  - Go to DATA with bit index=0.
- DATA:
  - tx = shift[bit index], each bit held CLKS_PER_BIT cycles.
  - Bit index increments 0..7; after bit 7's last cycle, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On its last cycle, tx_done is registered high, so it appears in the following cycle for exactly one cycle.
  - Next state: RD_REQ if fifo_empty=0, else IDLE.
- Latency: fifo_empty falls in IDLE cycle N -> fifo_r_en high in cycle N+1 -> tx falls in cycle N+3.
- Frame length:
  - START through STOP = 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are separated by exactly 2 tx-high cycles (RD_REQ, RD_WAIT).
  - Frame-start period = 10*CLKS_PER_BIT + 2.
- FIFO rules:
  - fifo_r_en is never asserted while fifo_empty=1.
  - fifo_empty is only sampled in IDLE and on STOP's last cycle.
  - fifo_data changes after RD_WAIT do not affect the frame in flight.
- Counter widths: baud counter is $clog2(CLKS_PER_BIT) bits; bit index is 3 bits; neither wraps outside its terminal count.
- Reset mid-operation:
  - Any state returns to IDLE on the next edge with tx=1.
  - An already-popped byte is dropped, not retransmitted.
  - A pending tx_done is cleared.
- Simultaneous reset and fifo_empty=0: reset wins; fifo_r_en stays 0 that cycle.

Test Plan:
1. Reset: rst=0 for 3 cycles with fifo_empty=0 -> tx=1, busy=0, fifo_r_en=0, tx_done=0 throughout; first fifo_r_en appears 1 cycle after rst=1.
2. Single byte, CLKS_PER_BIT=4, sync_fifo holding 0xA5:
   - Exactly one fifo_r_en pulse.
   - tx bits (each 4 cycles): 0,1,0,1,0,0,1,0,1,1.
   - One tx_done pulse, then IDLE with busy=0.
   - No further fifo_r_en.
3. Back-to-back, CLKS_PER_BIT=4, FIFO holding 0x20,0x29,0x33:
   - Three frames decode to 0x20, 0x29, 0x33.
   - Start-bit falling edges are exactly 42 cycles apart.
   - Three fifo_r_en pulses, three tx_done pulses.
   - FIFO empty=1 at the end.
4. Empty FIFO: fifo_empty=1 for 200 cycles -> fifo_r_en never high, tx=1, busy=0.
5. Reset mid-frame:
   - Assert rst=0 during data bit 3 of 0x55 -> tx=1 and busy=0 after that edge.
   - After release, remaining FIFO byte 0x0F is sent intact; 0x55 is not re-sent.
6. Write during transmit, CLKS_PER_BIT=4:
   - Push 0x12 and start its frame; write 0x99 into the FIFO mid-frame.
   - Frame 1 decodes 0x12 unaltered.
   - 0x99 follows after exactly 2 idle cycles.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from sync_fifo and sends them as 8N1 UART frames.
// Every output is a flop or a decode of flopped state.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    START,
    DATA,
    STOP
  } state_e;

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  state_e                state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  done_q, done_d;

  logic baud_last;
  logic bit_last;

  assign baud_last = (baud_q == BAUD_LAST);
  assign bit_last  = (bit_q == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = RD_REQ;
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: state_d = START;
      START:   if (baud_last) state_d = DATA;
      DATA:    if (baud_last && bit_last) state_d = STOP;
      STOP: begin
        if (baud_last) state_d = fifo_empty ? IDLE : RD_REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // Baud/bit counters restart at each terminal count; the byte is latched
  // once in RD_WAIT so later fifo_data changes cannot reach the frame.
  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    unique case (state_q)
      RD_WAIT: begin
        shift_d = fifo_data;
        baud_d  = '0;
        bit_d   = '0;
      end
      START: begin
        baud_d = baud_last ? '0 : baud_q + BW'(1);
        bit_d  = '0;
      end
      DATA: begin
        baud_d = baud_last ? '0 : baud_q + BW'(1);
        if (baud_last) bit_d = bit_last ? 3'd0 : bit_q + 3'd1;
      end
      STOP: begin
        baud_d = baud_last ? '0 : baud_q + BW'(1);
        done_d = baud_last;
      end
      default: begin
        baud_d = '0;
        bit_d  = '0;
      end
    endcase
  end

  always_comb begin
    fifo_r_en = 1'b0;
    busy      = 1'b1;
    tx        = 1'b1;
    unique case (state_q)
      IDLE:    busy = 1'b0;
      RD_REQ:  fifo_r_en = 1'b1;
      START:   tx = 1'b0;
      DATA:    tx = shift_q[bit_q];
      default: tx = 1'b1;
    endcase
  end

  assign tx_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx at 4 clocks per bit,
// fed by a small behavioural sync_fifo model.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_r_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [16];
  int wp = 0;
  int rp = 0;
  int cyc = 0;
  int rcnt = 0;
  int dcnt = 0;
  int viol = 0;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_WIDTH  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_r_en (fifo_r_en),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_r_en && (wp != rp)) begin
      fifo_data <= mem[rp % 16];
      rp <= rp + 1;
    end
  end

  always @(negedge clk) begin
    if (fifo_r_en) rcnt <= rcnt + 1;
    if (tx_done) dcnt <= dcnt + 1;
    if (fifo_r_en && fifo_empty) viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wp % 16] = d;
    wp = wp + 1;
  endtask

  task automatic wait_start(output int c, output bit ok);
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        c  = cyc;
        break;
      end
    end
    if (!ok) chk("rx_timeout", 32'd0, 32'd1);
  endtask

  // Returns {stop, data[7:0], start} sampled mid-bit; ends mid stop bit.
  task automatic recv(output logic [9:0] f, output int c);
    bit ok;
    f = '0;
    wait_start(c, ok);
    if (ok) begin
      repeat (CPB / 2) @(negedge clk);
      f[0] = tx;
      for (int i = 1; i < 10; i++) begin
        repeat (CPB) @(negedge clk);
        f[i] = tx;
      end
    end
  endtask

  logic [9:0] f1, f2, f3;
  int s1, s2, s3, r0, d0, t0;
  bit ok, flag;

  initial begin
    // reset held with a byte already waiting
    push(8'hA5);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out", {28'd0, tx, busy, fifo_r_en, tx_done}, 32'h8);
    end
    r0 = rcnt;
    d0 = dcnt;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_first_ren", {31'd0, fifo_r_en}, 32'd1);

    // single byte 0xA5
    recv(f1, s1);
    chk("a5_frame", {22'd0, f1}, 32'h34A);
    repeat (6) @(negedge clk);
    chk("a5_done", dcnt - d0, 32'd1);
    repeat (10) @(negedge clk);
    chk("a5_idle_busy", {31'd0, busy}, 32'd0);
    chk("a5_ren", rcnt - r0, 32'd1);

    // back-to-back 0x20 0x29 0x33
    r0 = rcnt;
    d0 = dcnt;
    push(8'h20);
    push(8'h29);
    push(8'h33);
    recv(f1, s1);
    recv(f2, s2);
    recv(f3, s3);
    chk("b2b_f1", {22'd0, f1}, 32'h240);
    chk("b2b_f2", {22'd0, f2}, 32'h252);
    chk("b2b_f3", {22'd0, f3}, 32'h266);
    chk("b2b_gap12", s2 - s1, 10 * CPB + 2);
    chk("b2b_gap23", s3 - s2, 10 * CPB + 2);
    repeat (8) @(negedge clk);
    chk("b2b_ren", rcnt - r0, 32'd3);
    chk("b2b_done", dcnt - d0, 32'd3);
    chk("b2b_empty", {31'd0, fifo_empty}, 32'd1);

    // empty fifo for 200 cycles
    r0 = rcnt;
    flag = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) flag = 1'b0;
    end
    chk("empty_quiet", {31'd0, flag}, 32'd1);
    chk("empty_ren", rcnt - r0, 32'd0);

    // reset during data bit 3 of 0x55
    r0 = rcnt;
    d0 = dcnt;
    push(8'h55);
    push(8'h0F);
    wait_start(t0, ok);
    repeat (4 * CPB + 1) @(negedge clk);
    chk("mid_bit3", {31'd0, tx}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    recv(f1, s1);
    chk("mid_after", {22'd0, f1}, 32'h21E);
    repeat (60) @(negedge clk);
    chk("mid_ren", rcnt - r0, 32'd2);
    chk("mid_done", dcnt - d0, 32'd1);
    chk("mid_idle", {31'd0, busy}, 32'd0);

    // write during transmit
    push(8'h12);
    fork
      recv(f1, s1);
      begin
        repeat (15) @(negedge clk);
        push(8'h99);
      end
    join
    recv(f2, s2);
    chk("wdt_f1", {22'd0, f1}, 32'h224);
    chk("wdt_f2", {22'd0, f2}, 32'h332);
    chk("wdt_gap", s2 - s1, 10 * CPB + 2);

    repeat (10) @(negedge clk);
    chk("ren_while_empty", viol, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
